// File: rtl/muldiv_issue_pkg.sv
// muldiv_issue_pkg: shared definitions for the execute-stage multiply/divide
// initiator.
//   - MULDIV_* : 4-bit M-extension op encodings.
//                bit3 = word op, bit2 = div/rem, bit1 = rem, bit0 = unsigned.
//   - muldivState_t : issue FSM state encoding, exposed for debug.
//   - helpers : op decode and 32->64 sign extension.
package muldiv_issue_pkg;

  localparam logic [3:0] MULDIV_MUL   = 4'b0000;
  localparam logic [3:0] MULDIV_DIV   = 4'b0100;
  localparam logic [3:0] MULDIV_DIVU  = 4'b0101;
  localparam logic [3:0] MULDIV_REM   = 4'b0110;
  localparam logic [3:0] MULDIV_REMU  = 4'b0111;
  localparam logic [3:0] MULDIV_MULW  = 4'b1000;
  localparam logic [3:0] MULDIV_DIVW  = 4'b1100;
  localparam logic [3:0] MULDIV_DIVUW = 4'b1101;
  localparam logic [3:0] MULDIV_REMW  = 4'b1110;
  localparam logic [3:0] MULDIV_REMUW = 4'b1111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } muldivState_t;

  // Every div/rem code is legal; among the multiply codes only mul and mulw.
  function automatic logic isEncoded(input logic [3:0] op);
    return op[2] || (op[1:0] == 2'b00);
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_issue_if.sv
// muldiv_issue_if: request/response bus between the issue logic and the
// multi-cycle multiply/divide unit.
//   Request : md_req_valid/md_req_ready handshake; a transfer happens in a
//             cycle where both are high. md_op/md_a/md_b hold steady while
//             md_req_valid is high. The issuer may drop md_req_valid before
//             acceptance (abandoned request).
//   Response: md_resp_valid is a one-cycle pulse carrying md_resp_data; there
//             is no backpressure, the issuer must take it when it arrives.
//   master modport = issuer, slave modport = unit.
interface muldiv_issue_if;
  logic        md_req_valid;
  logic        md_req_ready;
  logic [3:0]  md_op;
  logic [63:0] md_a;
  logic [63:0] md_b;
  logic        md_resp_valid;
  logic [63:0] md_resp_data;

  modport master (
    output md_req_valid, md_op, md_a, md_b,
    input  md_req_ready, md_resp_valid, md_resp_data
  );

  modport slave (
    input  md_req_valid, md_op, md_a, md_b,
    output md_req_ready, md_resp_valid, md_resp_data
  );
endinterface

// File: rtl/muldiv_issue_special.sv
// muldiv_special: combinational detection of RISC-V divide special cases on
// already-prepared operands. Present only when MULDIV_FASTPATH_EN is defined.
//   op    : M-extension op code
//   a, b  : prepared dividend / divisor
//   hit   : op is div/rem and divisor is zero or the signed case overflows
//   value : final (already sign-extended) result for a hit
`ifdef MULDIV_FASTPATH_EN
module muldiv_special
  import muldiv_issue_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        hit,
  output logic [63:0] value
);
  logic isWord;
  logic isRem;
  logic divByZero;
  logic overflow;
  logic [63:0] dividend;

  always_comb begin
    isWord    = op[3];
    isRem     = op[1];
    divByZero = isWord ? (b[31:0] == 32'd0) : (b == 64'd0);
    overflow  = !op[0] && (isWord ?
                ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF)) :
                ((a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF)));
    // Word results are always seen sign-extended from bit 31.
    dividend  = isWord ? sext32(a[31:0]) : a;
    hit   = 1'b0;
    value = '0;
    if (op[2]) begin
      if (divByZero) begin
        hit   = 1'b1;
        value = isRem ? dividend : '1;
      end else if (overflow) begin
        hit   = 1'b1;
        value = isRem ? 64'd0 : dividend;
      end
    end
  end
endmodule
`endif

// File: rtl/muldiv_issue.sv
// muldiv_issue: execute-stage initiator for the multi-cycle mul/div unit.
// Takes one op at a time, prepares word-op operands, runs the request /
// response exchange with the unit and stalls the pipeline until the result
// is back. Results are sign-extended for word ops and tagged with rd.
// Optional feature macro: MULDIV_FASTPATH_EN (divide special cases resolved
// locally in one cycle); without it every encoded op goes to the unit.
//   clk, reset         : clock, synchronous active-high reset
//   op_valid/op/srca/srcb/rd : op presented by the execute stage
//   flush              : kill the current op
//   stall              : hold the execute stage
//   result_valid/result/result_rd : one-cycle completion pulse with value/tag
//   md                 : master side of the unit bus (muldiv_issue_if)
//   dbgState           : current FSM state
module muldiv_issue
  import muldiv_issue_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [63:0]      srca,
  input  logic [63:0]      srcb,
  input  logic [TAG_W-1:0] rd,
  input  logic             flush,
  output logic             stall,
  output logic             result_valid,
  output logic [63:0]      result,
  output logic [TAG_W-1:0] result_rd,
  muldiv_issue_if.master   md,
  output muldivState_t     dbgState
);

  muldivState_t state;
  muldivState_t stateNext;

  logic [63:0] prepA;
  logic [63:0] prepB;
  logic        specHit;
  logic [63:0] specValue;
  logic        accept;
  logic [3:0]  mdOpQ;
  logic [63:0] mdAQ;
  logic [63:0] mdBQ;

  // Word div/rem see only the low 32 bits; signed forms sign-extend, unsigned
  // forms zero-extend. mulw and the 64-bit ops pass through.
  always_comb begin
    prepA = srca;
    prepB = srcb;
    if (op[3] && op[2]) begin
      if (op[0]) begin
        prepA = {32'd0, srca[31:0]};
        prepB = {32'd0, srcb[31:0]};
      end else begin
        prepA = sext32(srca[31:0]);
        prepB = sext32(srcb[31:0]);
      end
    end
  end

`ifdef MULDIV_FASTPATH_EN
  muldiv_special uSpecial (
    .op    (op),
    .a     (prepA),
    .b     (prepB),
    .hit   (specHit),
    .value (specValue)
  );
`else
  assign specHit   = 1'b0;
  assign specValue = '0;
`endif

  assign accept = (state == IDLE) && op_valid && !flush;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) stateNext = (!isEncoded(op) || specHit) ? DONE : REQ;
      end
      REQ: begin
        // An accepted request must have its response drained; an unaccepted
        // one can simply be withdrawn.
        if (flush)                 stateNext = md.md_req_ready ? DRAIN : IDLE;
        else if (md.md_req_ready)  stateNext = WAIT;
      end
      WAIT: begin
        if (flush)                 stateNext = md.md_resp_valid ? IDLE : DRAIN;
        else if (md.md_resp_valid) stateNext = DONE;
      end
      DONE:  stateNext = IDLE;
      DRAIN: begin
        if (md.md_resp_valid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are forced low during reset so the reset cycle itself is quiet.
  always_comb begin
    stall        = 1'b0;
    result_valid = 1'b0;
    md.md_req_valid = 1'b0;
    if (!reset) begin
      stall = accept || (state == REQ) || (state == WAIT) ||
              ((state == DRAIN) && op_valid);
      result_valid    = (state == DONE) && !flush;
      md.md_req_valid = (state == REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      result    <= '0;
      result_rd <= '0;
      mdOpQ     <= '0;
      mdAQ      <= '0;
      mdBQ      <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        mdOpQ     <= op;
        mdAQ      <= prepA;
        mdBQ      <= prepB;
        result_rd <= rd;
        // Only meaningful when the op completes locally (next state DONE).
        result    <= isEncoded(op) ? specValue : 64'd0;
      end else if ((state == WAIT) && md.md_resp_valid && !flush) begin
        result <= mdOpQ[3] ? sext32(md.md_resp_data[31:0]) : md.md_resp_data;
      end
    end
  end

  assign md.md_op = mdOpQ;
  assign md.md_a  = mdAQ;
  assign md.md_b  = mdBQ;
  assign dbgState = state;

endmodule

// File: tb/tb_muldiv_issue.sv
module tb_muldiv_issue;
  import muldiv_issue_pkg::*;

  localparam int TAG_W = 5;
`ifdef MULDIV_FASTPATH_EN
  localparam bit FAST_ON = 1'b1;
`else
  localparam bit FAST_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk;
  logic             reset;
  logic             opValid;
  logic [3:0]       opIn;
  logic [63:0]      srcaIn;
  logic [63:0]      srcbIn;
  logic [TAG_W-1:0] rdIn;
  logic             flush;
  logic             stall;
  logic             resultValid;
  logic [63:0]      result;
  logic [TAG_W-1:0] resultRd;
  muldivState_t     dbgState;

  muldiv_issue_if mdBus ();

  muldiv_issue #(.TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (opValid),
    .op           (opIn),
    .srca         (srcaIn),
    .srcb         (srcbIn),
    .rd           (rdIn),
    .flush        (flush),
    .stall        (stall),
    .result_valid (resultValid),
    .result       (result),
    .result_rd    (resultRd),
    .md           (mdBus.master),
    .dbgState     (dbgState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [63:0]      expQ[$];
  logic [TAG_W-1:0] expRdQ[$];
  int checkCount = 0;
  int failCount  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (RISC-V M semantics) ----------------
  function automatic bit encoded(input logic [3:0] o);
    return o inside {4'd0, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12, 4'd13, 4'd14, 4'd15};
  endfunction

  function automatic logic [63:0] ref_m(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0] a32, b32, r32;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    r32 = '0;
    case (o)
      MULDIV_MUL:  return a * b;
      MULDIV_DIV:  begin
        if (b == 0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        return sa / sb;
      end
      MULDIV_DIVU: return (b == 0) ? '1 : a / b;
      MULDIV_REM:  begin
        if (b == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
        return sa % sb;
      end
      MULDIV_REMU: return (b == 0) ? a : a % b;
      MULDIV_MULW: r32 = a32 * b32;
      MULDIV_DIVW: begin
        if (b32 == 0) r32 = '1;
        else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
        else r32 = sa32 / sb32;
      end
      MULDIV_DIVUW: r32 = (b32 == 0) ? '1 : a32 / b32;
      MULDIV_REMW: begin
        if (b32 == 0) r32 = a32;
        else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
        else r32 = sa32 % sb32;
      end
      MULDIV_REMUW: r32 = (b32 == 0) ? a32 : a32 % b32;
      default: return 64'd0;
    endcase
    return {{32{r32[31]}}, r32};
  endfunction

  function automatic logic [63:0] prep(input logic [3:0] o, input logic [63:0] x);
    if (o == MULDIV_DIVW || o == MULDIV_REMW)   return {{32{x[31]}}, x[31:0]};
    if (o == MULDIV_DIVUW || o == MULDIV_REMUW) return {32'd0, x[31:0]};
    return x;
  endfunction

  function automatic bit special(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    bit word, sgn, zero, ovf;
    if (!(o inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd14, 4'd15})) return 1'b0;
    word = (o >= 4'd8);
    sgn  = (o == MULDIV_DIV || o == MULDIV_REM || o == MULDIV_DIVW || o == MULDIV_REMW);
    zero = word ? (b[31:0] == 0) : (b == 0);
    ovf  = sgn && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
    return zero || ovf;
  endfunction

  // ---------------- unit model ----------------
  int          readyDelay = 0;
  int          respDelay  = 0;
  bit          uPending   = 0;
  int          uCount     = 0;
  int          uAge       = 0;
  logic [63:0] uData      = '0;

  // Word ops get junk in the upper half: the issuer must sign-extend bit 31.
  function automatic logic [63:0] unit_raw(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = ref_m(o, a, b);
    if (o[3]) r[63:32] = $urandom;
    return r;
  endfunction

  logic             sReqValid, sReady, sResp, sStall, sResultValid;
  logic [63:0]      sResult, sMdA, sMdB;
  logic [3:0]       sMdOp;
  logic [TAG_W-1:0] sResultRd;
  muldivState_t     sState;

  // Called at a negedge with inputs driven; samples, crosses the posedge,
  // advances the unit model and drives the unit's inputs for the next cycle.
  task automatic cycle();
    bit hsNow;
    #1;
    sReqValid = mdBus.md_req_valid; sReady = mdBus.md_req_ready;
    sResp = mdBus.md_resp_valid;    sStall = stall;
    sResultValid = resultValid;     sResult = result; sResultRd = resultRd;
    sMdOp = mdBus.md_op; sMdA = mdBus.md_a; sMdB = mdBus.md_b; sState = dbgState;
    hsNow = sReqValid && sReady;
    @(posedge clk);
    if (reset) begin
      uPending = 0; uAge = 0;
    end else begin
      if (sResp) uPending = 0;
      else if (uPending && uCount > 0) uCount--;
      if (hsNow) begin
        uPending = 1; uCount = respDelay; uAge = 0;
        uData = unit_raw(sMdOp, sMdA, sMdB);
      end else if (sReqValid) uAge++;
      else uAge = 0;
    end
    @(negedge clk);
    mdBus.md_resp_valid = uPending && (uCount == 0);
    mdBus.md_resp_data  = mdBus.md_resp_valid ? uData : {$urandom, $urandom};
    mdBus.md_req_ready  = !uPending && (uAge >= readyDelay);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] r);
    opValid = 1'b1; opIn = o; srcaIn = a; srcbIn = b; rdIn = r; flush = 1'b0;
  endtask

  // Presents one op, holds it while stalled and checks its completion.
  task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] r, input bit chkLat);
    logic [63:0] expA, expB;
    bit fast, done, stallOk, mdOk, reqSeen;
    int cyc, lat, expLat;
    expQ.push_back(ref_m(o, a, b));
    expRdQ.push_back(r);
    expA = prep(o, a); expB = prep(o, b);
    fast = !encoded(o) || (FAST_ON && special(o, a, b));
    expLat = fast ? 1 : 3 + readyDelay + respDelay;
    drive_op(o, a, b, r);
    done = 0; stallOk = 1; mdOk = 1; reqSeen = 0; cyc = 0; lat = 0;
    while (!done && cyc < 64) begin
      cycle();
      if (sReqValid) begin
        reqSeen = 1;
        if (sMdOp !== o || sMdA !== expA || sMdB !== expB) mdOk = 0;
      end
      if (sResultValid) begin
        done = 1; lat = cyc;
        check("result", sResult, expQ.pop_front());
        check("result_rd", sResultRd, expRdQ.pop_front());
        check("stall_in_done", sStall, 1'b0);
      end else if (!sStall) stallOk = 0;
      cyc++;
    end
    if (!done) begin
      void'(expQ.pop_front()); void'(expRdQ.pop_front());
    end
    check("completed", done, 1'b1);
    check("stall_held", stallOk, 1'b1);
    check("md_req_used", reqSeen, !fast);
    check("md_operands", mdOk, 1'b1);
    if (chkLat) check("latency", lat, expLat);
  endtask

  task automatic idle(input int n);
    bit noisy;
    opValid = 1'b0; flush = 1'b0; noisy = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (sResultValid || sStall || sReqValid) noisy = 1;
    end
    check("idle_quiet", noisy, 1'b0);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return {$urandom, 32'h8000_0000};
      4: return 64'($urandom_range(0, 20));
      5: return {$urandom, 32'h0};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [3:0] opList[12] = '{4'd0, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                             4'd12, 4'd13, 4'd14, 4'd15, 4'd3, 4'd9};

  initial begin
    reset = 1'b1; opValid = 1'b0; opIn = '0; srcaIn = '0; srcbIn = '0; rdIn = '0; flush = 1'b0;
    mdBus.md_req_ready = 1'b0; mdBus.md_resp_valid = 1'b0; mdBus.md_resp_data = '0;
    @(negedge clk);
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    check("rst_state", 64'(sState), 64'(IDLE));
    check("rst_stall", sStall, 1'b0);
    check("rst_result_valid", sResultValid, 1'b0);
    check("rst_req_valid", sReqValid, 1'b0);
    check("rst_result", sResult, 64'd0);
    check("rst_result_rd", sResultRd, '0);
    check("rst_md_op", sMdOp, 4'd0);
    check("rst_md_a", sMdA, 64'd0);
    check("rst_md_b", sMdB, 64'd0);

    // mul 7*6: acked after 2 request cycles, response 3 cycles later
    readyDelay = 2; respDelay = 2;
    run_op(MULDIV_MUL, 64'd7, 64'd6, 5'd1, 1'b1);
    idle(2);

    readyDelay = 0; respDelay = 0;
    run_op(MULDIV_DIVW, 64'h0000_0000_8000_0000, '1, 5'd2, 1'b1);
    run_op(MULDIV_REMU, 64'h1234, 64'd0, 5'd3, 1'b1);
    run_op(MULDIV_DIVU, 64'h55, 64'd0, 5'd4, 1'b1);
    run_op(MULDIV_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 5'd5, 1'b1);
    run_op(4'b0010, 64'd9, 64'd9, 5'd6, 1'b1);
    idle(1);

    // flush while waiting for the response, no response that cycle
    readyDelay = 0; respDelay = 4;
    drive_op(MULDIV_DIVU, 64'd100, 64'd7, 5'd7);
    cycle(); cycle();
    flush = 1'b1; cycle();
    flush = 1'b0; opValid = 1'b0; cycle();
    check("wait_flush_state", 64'(sState), 64'(DRAIN));
    check("wait_flush_stall", sStall, 1'b0);
    idle(6);
    check("drain_exit", 64'(sState), 64'(IDLE));
    run_op(MULDIV_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 1'b1);

    // flush in REQ without acceptance: request withdrawn
    readyDelay = 3; respDelay = 1;
    drive_op(MULDIV_DIV, 64'd50, 64'd5, 5'd9);
    cycle();
    flush = 1'b1; cycle();
    flush = 1'b0; opValid = 1'b0; cycle();
    check("req_flush_state", 64'(sState), 64'(IDLE));
    check("req_flush_req_valid", sReqValid, 1'b0);
    check("req_flush_no_accept", uPending, 1'b0);
    idle(3);

    // flush in REQ with acceptance the same cycle, next op waits out DRAIN
    readyDelay = 0; respDelay = 2;
    drive_op(MULDIV_MULW, 64'd3, 64'd4, 5'd10);
    cycle();
    flush = 1'b1; cycle();
    flush = 1'b0; opValid = 1'b0; cycle();
    check("req_ack_flush_state", 64'(sState), 64'(DRAIN));
    check("req_ack_flush_stall", sStall, 1'b0);
    run_op(MULDIV_DIVUW, 64'd1000, 64'd10, 5'd11, 1'b0);

    // flush in WAIT with the response arriving the same cycle
    readyDelay = 0; respDelay = 0;
    drive_op(MULDIV_MUL, 64'd11, 64'd13, 5'd12);
    cycle(); cycle();
    flush = 1'b1; cycle();
    check("wait_resp_flush_rv", sResultValid, 1'b0);
    flush = 1'b0; opValid = 1'b0; cycle();
    check("wait_resp_flush_state", 64'(sState), 64'(IDLE));
    check("wait_resp_flush_rv2", sResultValid, 1'b0);

    // flush in DONE: no completion pulse
    drive_op(4'b1011, 64'd1, 64'd1, 5'd13);
    cycle();
    flush = 1'b1; cycle();
    check("done_flush_rv", sResultValid, 1'b0);
    check("done_flush_stall", sStall, 1'b0);
    flush = 1'b0; opValid = 1'b0; cycle();
    check("done_flush_state", 64'(sState), 64'(IDLE));

    // flush together with op_valid in IDLE: nothing accepted
    drive_op(MULDIV_MUL, 64'd2, 64'd2, 5'd14);
    flush = 1'b1; cycle();
    check("idle_flush_stall", sStall, 1'b0);
    flush = 1'b0; opValid = 1'b0; cycle();
    check("idle_flush_state", 64'(sState), 64'(IDLE));
    check("idle_flush_req", sReqValid, 1'b0);

    // reset while a request is outstanding
    readyDelay = 4; respDelay = 0;
    drive_op(MULDIV_DIV, 64'd81, 64'd9, 5'd15);
    cycle();
    reset = 1'b1; opValid = 1'b0; cycle();
    reset = 1'b0; cycle();
    check("mid_rst_req_valid", sReqValid, 1'b0);
    check("mid_rst_stall", sStall, 1'b0);
    check("mid_rst_result_valid", sResultValid, 1'b0);
    check("mid_rst_state", 64'(sState), 64'(IDLE));

    // randomized ops, back-to-back or with short gaps
    for (int n = 0; n < 150; n++) begin
      int gap;
      readyDelay = $urandom_range(0, 3);
      respDelay  = $urandom_range(0, 3);
      run_op(opList[$urandom_range(0, 11)], pick_operand(), pick_operand(),
             TAG_W'($urandom), 1'b1);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/muldiv_issue.md
# muldiv_issue

Execute-stage initiator for the multi-cycle multiply/divide unit. Accepts one M-extension op at a time from the execute stage, preprocesses operands for word ops, runs a valid/ready request and valid-only response handshake with the unit, and stalls the pipeline until the result is back. Resolves RISC-V divide special cases locally and discards in-flight results on flush. Results are returned sign-extended and tagged with the destination register.

## Interface
Parameters:
- TAG_W, 5, destination-register tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  execute stage holds an M-extension op
- op  in  u4  encoding: 0000 mul, 0100 div, 0101 divu, 0110 rem, 0111 remu, 1000 mulw, 1100 divw, 1101 divuw, 1110 remw, 1111 remuw
- srca, srcb  in  u64  rs1, rs2 values
- rd  in  TAG_W  destination tag
- flush  in  1  kill current op
- stall  out  1  hold execute stage
- result_valid  out  1  one-cycle completion pulse
- result  out  u64  final value
- result_rd  out  TAG_W  tag of completing op
- md_req_valid  out  1  request to unit
- md_req_ready  in  1  unit accepts request
- md_op  out  u4  op forwarded
- md_a, md_b  out  u64  preprocessed operands
- md_resp_valid  in  1  unit result valid (no backpressure)
- md_resp_data  in  u64  unit raw result

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: op_valid and not flush -> latch op/operands/rd. Special case or unencoded op -> DONE; else REQ.
- REQ: md_req_valid=1. md_req_ready -> WAIT.
- WAIT: md_resp_valid -> capture data, DONE.
- DONE: result_valid=1, stall=0; op_valid in this cycle is the completing op and is ignored. -> IDLE.
- DRAIN: wait for md_resp_valid, discard, -> IDLE.
- Operand prep: div/rem word signed ops sign-extend low 32 bits of both operands; divuw/remuw zero-extend them; mulw passes the operands unchanged; 64-bit ops pass through.
- Result: word ops sign-extend bit 31 of the raw result; 64-bit ops pass through.
- Special cases, evaluated on prepared operands:
  - Divisor 0: div* returns all ones; rem* returns the prepared dividend, sign-extended from bit 31 for word ops.
  - Signed overflow (dividend = most-negative value, divisor = -1, at op width): div returns the dividend; rem returns 0.
- Unencoded op: result 0 via DONE, never sent to the unit.
- Flush:
  - IDLE or DONE: nothing latched or emitted.
  - REQ: with md_req_ready the same cycle -> DRAIN; otherwise withdraw the request and go to IDLE. The unit's contract permits abandoning an unaccepted request.
  - WAIT: md_resp_valid the same cycle -> IDLE with no result; otherwise DRAIN.
- result_valid is never asserted in a cycle in which flush is high.
- stall = (IDLE and op_valid and not flush) or state in {REQ, WAIT} or (DRAIN and op_valid).
- Reset: state IDLE; stall, result_valid, md_req_valid = 0; result, result_rd, md_* data = 0.

## Timing
- Fast path: accept in cycle N, result_valid in cycle N+1.
- Unit path: accept N; md_req_valid from N+1 until the handshake cycle H; response captured in cycle R ≥ H+1; result_valid at R+1.
- md_op/md_a/md_b are stable while md_req_valid is high.
- Back-to-back ops: a new op is accepted no earlier than the cycle after DONE.
- Reset mid-op overrides all state; the unit shares the reset, so no response is left outstanding.

## Configuration
- MULDIV_FASTPATH_EN defined: special cases are resolved locally as above with 1-cycle latency.
- MULDIV_FASTPATH_EN undefined: all encoded ops go to the unit, which must produce the RISC-V special-case results itself. Unencoded ops still complete locally with result 0.

## Structure
- common package: u4 op constants (MULDIV_MUL … MULDIV_REMUW) and the muldiv_issue state enum.
- Sub-module muldiv_special: combinational; inputs are the prepared operands and op; outputs are the hit flag and the special-case value. Compiled in only under MULDIV_FASTPATH_EN.

## Test plan
- mul, srca=7, srcb=6, unit acks after 2 cycles, responds 3 cycles later -> result 42, stall high throughout, exactly one result_valid pulse.
- divw, srca=0x00000000_80000000, srcb=0xFFFFFFFF_FFFFFFFF, macro on -> result 0xFFFFFFFF_80000000 at N+1, md_req_valid never asserted.
- remu, srcb=0, srca=0x1234 -> result 0x1234 at N+1. divu, srcb=0 -> result all ones.
- divuw, srca=0xFFFFFFFF_FFFFFFFE, srcb=2 -> md_a=0x00000000_FFFFFFFE, md_b=2; unit returns 0x7FFFFFFF -> result 0x00000000_7FFFFFFF.
- flush in WAIT with no response -> stall low, state DRAIN; late response discarded, no result_valid; next op issues normally.
- reset asserted during REQ -> next cycle md_req_valid=0, stall=0, result_valid=0.
